// File: rtl/issue_unit_rr.sv
// Round-robin warp issue arbiter: same-cycle one-hot grant, registered capture stage and saturating issue counter.
// Optional per-warp starvation priority is enabled by defining ISSUE_STARVATION_EN.
module issue_unit_rr #(
    parameter int unsigned NUM_WARPS    = 8,
    parameter int unsigned WID_W        = $clog2(NUM_WARPS),
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_WARPS-1:0] IB_Ready_Issue,
    input  logic                 OC_Full,
    output logic [NUM_WARPS-1:0] IU_Grant,
    output logic [WID_W-1:0]     IU_Sel_Warp,
    output logic                 IU_Valid_OC,
    output logic [WID_W-1:0]     IU_Warp_ID_OC,
    output logic [WID_W-1:0]     IU_Ptr,
    output logic [31:0]          IU_Issue_Count
);

    logic [WID_W-1:0]     r_ptr;
    logic                 r_valid;
    logic [WID_W-1:0]     r_wid;
    logic [31:0]          r_cnt;

    logic [NUM_WARPS-1:0] w_elig;
    logic [NUM_WARPS-1:0] w_scan;
    logic [NUM_WARPS-1:0] w_grant;
    logic [WID_W-1:0]     w_sel;
    logic [WID_W-1:0]     w_idx;
    logic                 w_found;

`ifdef ISSUE_STARVATION_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]     r_skip [NUM_WARPS];
    logic [NUM_WARPS-1:0] w_starved;

    // Gated by eligibility so a full operand collector never produces a grant.
    always_comb begin
        w_starved = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            w_starved[w] = w_elig[w] && (r_skip[w] == CNT_W'(STARVE_LIMIT));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                r_skip[w] <= '0;
            end
        end else if (!OC_Full) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                if (w_grant[w] || !IB_Ready_Issue[w]) begin
                    r_skip[w] <= '0;
                end else if (w_found && (r_skip[w] != CNT_W'(STARVE_LIMIT))) begin
                    r_skip[w] <= r_skip[w] + CNT_W'(1);
                end
            end
        end
    end
`endif

    always_comb begin
        w_elig = OC_Full ? '0 : IB_Ready_Issue;
        w_scan = w_elig;
`ifdef ISSUE_STARVATION_EN
        if (|w_starved) begin
            w_scan = w_starved;
        end
`endif
        w_grant = '0;
        w_sel   = r_ptr;
        w_idx   = '0;
        w_found = 1'b0;
        // NUM_WARPS is a power of two, so the index wraps naturally in WID_W bits.
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
            w_idx = r_ptr + WID_W'(i);
            if (!w_found && w_scan[w_idx]) begin
                w_found        = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_sel          = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_wid   <= '0;
            r_cnt   <= '0;
        end else begin
            r_valid <= w_found;
            if (w_found) begin
                r_ptr <= w_sel + WID_W'(1);
                r_wid <= w_sel;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
        end
    end

    assign IU_Grant       = w_grant;
    assign IU_Sel_Warp    = w_sel;
    assign IU_Valid_OC    = r_valid;
    assign IU_Warp_ID_OC  = r_wid;
    assign IU_Ptr         = r_ptr;
    assign IU_Issue_Count = r_cnt;

endmodule

// File: tb/tb_issue_unit_rr.sv
// Directed self-checking bench for issue_unit_rr (default build, NUM_WARPS=8).
module tb_issue_unit_rr;

    logic        clk;
    logic        rst_n;
    logic [7:0]  IB_Ready_Issue;
    logic        OC_Full;
    logic [7:0]  IU_Grant;
    logic [2:0]  IU_Sel_Warp;
    logic        IU_Valid_OC;
    logic [2:0]  IU_Warp_ID_OC;
    logic [2:0]  IU_Ptr;
    logic [31:0] IU_Issue_Count;

    int n_checks = 0;
    int n_errors = 0;

    issue_unit_rr #(.NUM_WARPS(8), .WID_W(3), .STARVE_LIMIT(15)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .IB_Ready_Issue (IB_Ready_Issue),
        .OC_Full        (OC_Full),
        .IU_Grant       (IU_Grant),
        .IU_Sel_Warp    (IU_Sel_Warp),
        .IU_Valid_OC    (IU_Valid_OC),
        .IU_Warp_ID_OC  (IU_Warp_ID_OC),
        .IU_Ptr         (IU_Ptr),
        .IU_Issue_Count (IU_Issue_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        IB_Ready_Issue = 8'h00;
        OC_Full        = 1'b0;
        #2;
        chk("rst_grant", 32'(IU_Grant), 32'h0);
        chk("rst_sel", 32'(IU_Sel_Warp), 32'h0);
        chk("rst_valid", 32'(IU_Valid_OC), 32'h0);
        chk("rst_wid", 32'(IU_Warp_ID_OC), 32'h0);
        chk("rst_ptr", 32'(IU_Ptr), 32'h0);
        chk("rst_cnt", IU_Issue_Count, 32'h0);
        tick();
        rst_n = 1'b1;

        // Idle: no requests for 4 cycles
        for (int i = 0; i < 4; i++) begin
            #1 chk("idle_grant", 32'(IU_Grant), 32'h0);
            tick();
            chk("idle_valid", 32'(IU_Valid_OC), 32'h0);
            chk("idle_ptr", 32'(IU_Ptr), 32'h0);
            chk("idle_cnt", IU_Issue_Count, 32'h0);
        end

        // All warps requesting: strict rotation 0..7,0,1
        IB_Ready_Issue = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("rot_grant", 32'(IU_Grant), 32'(8'h01 << (i % 8)));
            chk("rot_sel", 32'(IU_Sel_Warp), 32'(i % 8));
            tick();
            chk("rot_valid", 32'(IU_Valid_OC), 32'h1);
            chk("rot_wid", 32'(IU_Warp_ID_OC), 32'(i % 8));
            chk("rot_ptr", 32'(IU_Ptr), 32'((i + 1) % 8));
        end
        chk("rot_cnt", IU_Issue_Count, 32'd10);

        // Move pointer from 2 to 3 via a single grant to warp 2
        IB_Ready_Issue = 8'h04;
        #1 chk("p3_grant", 32'(IU_Grant), 32'h04);
        tick();
        chk("p3_ptr", 32'(IU_Ptr), 32'd3);

        // Requests {2,5} with pointer 3: scan 3,4,5 picks warp 5
        IB_Ready_Issue = 8'h24;
        #1;
        chk("wrap_grant", 32'(IU_Grant), 32'h20);
        chk("wrap_sel", 32'(IU_Sel_Warp), 32'd5);
        tick();
        chk("wrap_ptr", 32'(IU_Ptr), 32'd6);
        chk("wrap_wid", 32'(IU_Warp_ID_OC), 32'd5);
        chk("wrap_cnt", IU_Issue_Count, 32'd12);

        // Backpressure: no grants, state holds
        IB_Ready_Issue = 8'hFF;
        OC_Full        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_grant", 32'(IU_Grant), 32'h0);
            chk("bp_sel", 32'(IU_Sel_Warp), 32'd6);
            tick();
            chk("bp_valid", 32'(IU_Valid_OC), 32'h0);
            chk("bp_ptr", 32'(IU_Ptr), 32'd6);
            chk("bp_cnt", IU_Issue_Count, 32'd12);
            chk("bp_wid", 32'(IU_Warp_ID_OC), 32'd5);
        end
        OC_Full = 1'b0;
        #1 chk("resume_grant", 32'(IU_Grant), 32'h40);
        tick();
        chk("resume_ptr", 32'(IU_Ptr), 32'd7);
        chk("resume_cnt", IU_Issue_Count, 32'd13);

        // Sole requester warp 6: back-to-back grants
        IB_Ready_Issue = 8'h40;
        for (int i = 0; i < 3; i++) begin
            #1 chk("solo_grant", 32'(IU_Grant), 32'h40);
            tick();
            chk("solo_valid", 32'(IU_Valid_OC), 32'h1);
            chk("solo_wid", 32'(IU_Warp_ID_OC), 32'd6);
            chk("solo_ptr", 32'(IU_Ptr), 32'd7);
        end
        chk("solo_cnt", IU_Issue_Count, 32'd16);

        // Set pointer to 5 with a valid issue, then reset mid-cycle
        IB_Ready_Issue = 8'h10;
        tick();
        chk("pre_rst_ptr", 32'(IU_Ptr), 32'd5);
        chk("pre_rst_valid", 32'(IU_Valid_OC), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ptr", 32'(IU_Ptr), 32'h0);
        chk("async_valid", 32'(IU_Valid_OC), 32'h0);
        chk("async_wid", 32'(IU_Warp_ID_OC), 32'h0);
        chk("async_cnt", IU_Issue_Count, 32'h0);
        IB_Ready_Issue = 8'h30;
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst_grant", 32'(IU_Grant), 32'h10);
        chk("post_rst_sel", 32'(IU_Sel_Warp), 32'd4);
        tick();
        chk("post_rst_ptr", 32'(IU_Ptr), 32'd5);
        chk("post_rst_wid", 32'(IU_Warp_ID_OC), 32'd4);
        chk("post_rst_cnt", IU_Issue_Count, 32'd1);
        #1 chk("post_rst_grant2", 32'(IU_Grant), 32'h20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
